dec32_encoder_seq: RTL and testbench
====================================

Name: dec32_encoder_seq

Overview:
- Sequential packer from internal decimal fields to IEEE 754-2008 decimal32 (DPD) interchange format.
- This is the encode-direction counterpart of the decimal datapath's BCD-field decoder.
- Inputs: sign, unbiased exponent, 7-digit BCD coefficient and special class.
- Adjusts the exponent into range (digit shifts, one per cycle), rounds half-even, then emits one DPD declet per cycle.
- Output is a 32-bit word plus a 4-bit flag vector on a valid/ready stream.

Parameters:
BIAS, 101, decimal32 exponent bias
QMAX, 90, largest unbiased exponent (biased 191)
QMIN, -101, smallest unbiased exponent (biased 0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input word valid
in_ready  out  1  block can accept (high only in IDLE)
in_sign  in  1  sign
in_exp  in  10  unbiased exponent, two's complement
in_coef  in  28  7 BCD digits, [27:24] is the MSD
in_special  in  2  class: 00 finite, 01 infinity, 10 qNaN, 11 sNaN
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  32  decimal32 word
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - out_valid=0, out_result=0, out_flags=0; internal guard, sticky and shift count cleared.
  - Applies mid-operation; any in-flight work is discarded.
- States: IDLE, ADJUST, ROUND, ENC_HI, ENC_LO, DONE.
- IDLE: in_ready=1. When in_valid is high, latch the inputs and go to ADJUST.
- ADJUST: one decision per cycle, evaluated in this priority order:
  - Special input: go to DONE with
    - infinity: {sign, 11110, 26'b0};
    - qNaN: {sign, 11111, 26'b0};
    - sNaN: same word as qNaN, plus the invalid flag.
  - exp>90 and coef==0: set exp=90, go to ROUND.
  - exp>90, MSD==0, coef!=0: shift coef left one digit, exp-=1 (fold-down).
  - exp>90, MSD!=0: overflow. Result {sign, 11110, 26'b0}, flags overflow|inexact, go to DONE.
  - exp<-101: shift coef right one digit, exp+=1.
    - Dropped digit goes to guard; sticky |= (old guard != 0).
    - After 8 consecutive right shifts, coef and guard are all zero: set exp=-101 in that same cycle and keep sticky.
  - Otherwise: go to ROUND.
- ROUND (1 cycle):
  - Increment coef (BCD) if guard>5, or guard==5 and (sticky or LSD odd).
  - Carry out of 9999999: coef=1000000, exp+=1.
  - inexact = (guard!=0 or sticky).
  - underflow = inexact and at least one right shift occurred.
- ENC_HI: out_result[19:10] = DPD(digits 6..4). ENC_LO: out_result[9:0] = DPD(digits 3..1).
  - DPD uses the IEEE 754-2008 declet table.
  - Digit numbering: digit 7 = MSD d, digit 1 = LSD.
  - Also in ENC_LO, with E = exp+101 (8 bits):
    - [30:26] = {E[7:6], d[2:0]} if d<=7, else {2'b11, E[7:6], d[0]};
    - [25:20] = E[5:0];
    - [31] = sign.
- DONE: out_valid=1; out_result and out_flags held stable until out_ready. On out_valid&out_ready go to IDLE; out_valid falls on the next edge.
- Latency from the accept edge to out_valid high:
  - finite: 4+s edges (s = number of ADJUST shift cycles);
  - special or overflow: 2+s edges.
- No overlap: one word in flight. in_ready=0 in every state except IDLE.
- Exponent arithmetic uses 11-bit signed internally; no wrap.

Optional Feature:
- Macro DEC32_FOLD_DOWN_EN.
- Defined: fold-down left shifts as described.
- Undefined: any exp>90 with coef!=0 is immediate overflow (+/-inf, flags overflow|inexact). exp>90 with coef==0 still clamps to 90.

Test Plan:
1. Reset -> handshake -> fields: release rst_n, then sign=0, exp=0, coef=0x0000001, finite -> in_ready high after reset; out_result=0x22500001, flags=0000, out_valid 4 edges after accept.
2. Maximum finite: exp=90, coef=0x9999999 -> out_result=0x77F3FCFF, flags=0000.
3. Overflow and sNaN:
   - exp=91, coef=0x1000000 -> 0x78000000, flags=0101, latency 2.
   - in_special=11 -> 0x7C000000, flags=1000.
4. Fold-down, exp=95, coef=0x0000001:
   - with DEC32_FOLD_DOWN_EN: 5 left shifts -> 0x43F20000, flags=0000, latency 9;
   - without: 0x78000000, flags=0101.
5. Subnormal rounding: exp=-103, coef=0x1234567 -> coef 0012346 at biased exp 0, out_result=0x000049C6, flags=0011, latency 6.
6. Backpressure and mid-operation reset:
   - Hold out_ready=0 for 10 cycles -> out_valid, result and flags stable; in_ready=0.
   - Pull rst_n low during ADJUST -> next edge out_valid=0, out_result=0, out_flags=0.
   - After rst_n rises -> in_ready=1.

Source files
------------

// File: rtl/dec32_encoder_seq.sv
// Packs sign/exponent/BCD coefficient into a decimal32 DPD word. Optional fold-down: DEC32_FOLD_DOWN_EN.
// Latency: finite 4+s edges, special/overflow 2+s edges (s = ADJUST shift cycles); one word in flight.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready.
module dec32_encoder_seq #(
  parameter int BIAS = 101,
  parameter int QMAX = 90,
  parameter int QMIN = -101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [27:0] in_coef,
  input  logic [1:0]  in_special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam logic signed [10:0] QMAX_E = 11'(QMAX);
  localparam logic signed [10:0] QMIN_E = 11'(QMIN);
  localparam logic signed [10:0] BIAS_E = 11'(BIAS);

  typedef enum logic [2:0] {S_IDLE, S_ADJUST, S_ROUND, S_ENC_HI, S_ENC_LO, S_DONE} state_t;

  state_t             state;
  logic               sign_q;
  logic signed [10:0] exp_q;
  logic [27:0]        coef_q;
  logic [1:0]         special_q;
  logic [3:0]         guard;
  logic               sticky;
  logic [3:0]         rshift_cnt;

  logic               round_up;
  logic               inexact;
  logic               coef_carry;
  logic [27:0]        coef_inc;
  logic [7:0]         e_biased;
  logic [4:0]         comb_field;

  function automatic logic [9:0] dpd_enc(input logic [11:0] bcd);
    logic [3:0] a, b, c;
    logic [9:0] r;
    a = bcd[11:8];
    b = bcd[7:4];
    c = bcd[3:0];
    case ({a[3], b[3], c[3]})
      3'b000:  r = {a[2:0], b[2:0], 1'b0, c[2:0]};
      3'b001:  r = {a[2:0], b[2:0], 1'b1, 2'b00, c[0]};
      3'b010:  r = {a[2:0], c[2:1], b[0], 1'b1, 2'b01, c[0]};
      3'b100:  r = {c[2:1], a[0], b[2:0], 1'b1, 2'b10, c[0]};
      3'b110:  r = {c[2:1], a[0], 2'b00, b[0], 1'b1, 2'b11, c[0]};
      3'b101:  r = {b[2:1], a[0], 2'b01, b[0], 1'b1, 2'b11, c[0]};
      3'b011:  r = {a[2:0], 2'b10, b[0], 1'b1, 2'b11, c[0]};
      default: r = {2'b00, a[0], 2'b11, b[0], 1'b1, 2'b11, c[0]};
    endcase
    return r;
  endfunction

  function automatic logic [28:0] bcd_inc7(input logic [27:0] c);
    logic [27:0] r;
    logic        cy;
    r  = c;
    cy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (cy) begin
        if (c[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = c[i*4 +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
    end
    return {cy, r};
  endfunction

  assign in_ready = (state == S_IDLE);
  assign e_biased = 8'(exp_q + BIAS_E);

  always_comb begin
    round_up   = (guard > 4'd5) || ((guard == 4'd5) && (sticky || coef_q[0]));
    inexact    = (guard != 4'd0) || sticky;
    {coef_carry, coef_inc} = bcd_inc7(coef_q);
    // MSD 8/9 moves into the combination field's large-digit form
    comb_field = coef_q[27] ? {2'b11, e_biased[7:6], coef_q[24]}
                            : {e_biased[7:6], coef_q[26:24]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      guard      <= '0;
      sticky     <= 1'b0;
      rshift_cnt <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      coef_q     <= '0;
      special_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sign_q     <= in_sign;
          exp_q      <= {in_exp[9], in_exp};
          coef_q     <= in_coef;
          special_q  <= in_special;
          guard      <= '0;
          sticky     <= 1'b0;
          rshift_cnt <= '0;
          out_result <= '0;
          out_flags  <= '0;
          state      <= S_ADJUST;
        end
        S_ADJUST: begin
          if (special_q != 2'b00) begin
            out_result <= {sign_q, (special_q == 2'b01) ? 5'b11110 : 5'b11111, 26'b0};
            out_flags  <= (special_q == 2'b11) ? 4'b1000 : 4'b0000;
            state      <= S_DONE;
          end else if (exp_q > QMAX_E) begin
            if (coef_q == 28'd0) begin
              exp_q <= QMAX_E;
              state <= S_ROUND;
            end
`ifdef DEC32_FOLD_DOWN_EN
            else if (coef_q[27:24] == 4'd0) begin
              coef_q <= {coef_q[23:0], 4'h0};
              exp_q  <= exp_q - 11'sd1;
            end
`endif
            else begin
              out_result <= {sign_q, 5'b11110, 26'b0};
              out_flags  <= 4'b0101;
              state      <= S_DONE;
            end
          end else if (exp_q < QMIN_E) begin
            coef_q     <= {4'h0, coef_q[27:4]};
            guard      <= coef_q[3:0];
            sticky     <= sticky | (guard != 4'd0);
            rshift_cnt <= rshift_cnt + 4'd1;
            // eighth shift has flushed every digit; further shifts change nothing but sticky
            exp_q      <= (rshift_cnt == 4'd7) ? QMIN_E : exp_q + 11'sd1;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (round_up) begin
            if (coef_carry) begin
              coef_q <= 28'h1000000;
              exp_q  <= exp_q + 11'sd1;
            end else begin
              coef_q <= coef_inc;
            end
          end
          out_flags[1:0] <= {inexact && (rshift_cnt != 4'd0), inexact};
          state          <= S_ENC_HI;
        end
        S_ENC_HI: begin
          out_result[19:10] <= dpd_enc(coef_q[23:12]);
          state             <= S_ENC_LO;
        end
        S_ENC_LO: begin
          out_result[31:20] <= {sign_q, comb_field, e_biased[5:0]};
          out_result[9:0]   <= dpd_enc(coef_q[11:0]);
          out_valid         <= 1'b1;
          state             <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec32_encoder_seq.sv
// Table-driven bench for dec32_encoder_seq with an expected-result queue and multi-cycle corner sequences.
module tb_dec32_encoder_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [9:0]  in_exp;
  logic [27:0] in_coef;
  logic [1:0]  in_special;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  always #5 clk = ~clk;

  dec32_encoder_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_coef(in_coef), .in_special(in_special),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [27:0] coef;
    logic [1:0]  special;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_res_q[$];
  logic [3:0]  exp_flg_q[$];
  int          exp_lat_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input int s, input int e, input logic [27:0] c, input int sp,
                     input logic [31:0] r, input logic [3:0] f, input int l);
    vec_t v;
    v.sign = s[0]; v.exp = 10'(e); v.coef = c; v.special = sp[1:0];
    v.res = r; v.flg = f; v.lat = l;
    vecs.push_back(v);
  endtask

  task automatic run(input vec_t v, input int hold, input string name);
    int          lat;
    logic [31:0] r;
    logic [3:0]  f;
    int          l;
    @(negedge clk);
    out_ready  = (hold == 0);
    in_valid   = 1'b1;
    in_sign    = v.sign;
    in_exp     = v.exp;
    in_coef    = v.coef;
    in_special = v.special;
    exp_res_q.push_back(v.res);
    exp_flg_q.push_back(v.flg);
    exp_lat_q.push_back(v.lat);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    r = exp_res_q.pop_front();
    f = exp_flg_q.pop_front();
    l = exp_lat_q.pop_front();
    check({name, "_result"}, out_result, r);
    check({name, "_flags"}, 32'(out_flags), 32'(f));
    check({name, "_latency"}, 32'(lat), 32'(l));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_vld_rdy"}, {30'd0, out_valid, in_ready}, 32'b10);
      check({name, "_hold_word"}, out_result ^ 32'(out_flags), r ^ 32'(f));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_coef = '0; in_special = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {out_result[27:0], out_flags, 3'b0, out_valid} | {28'd0, out_result[31:28]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    add(0,    0, 28'h0000001, 0, 32'h22500001, 4'b0000, 4);
    add(0,   90, 28'h9999999, 0, 32'h77F3FCFF, 4'b0000, 4);
    add(0,   91, 28'h1000000, 0, 32'h78000000, 4'b0101, 2);
    add(0,    0, 28'h0000000, 3, 32'h7C000000, 4'b1000, 2);
`ifdef DEC32_FOLD_DOWN_EN
    add(0,   95, 28'h0000001, 0, 32'h43F20000, 4'b0000, 9);
`else
    add(0,   95, 28'h0000001, 0, 32'h78000000, 4'b0101, 2);
`endif
    add(0, -103, 28'h1234567, 0, 32'h000049C6, 4'b0011, 6);
    add(1,    0, 28'h0000000, 1, 32'hF8000000, 4'b0000, 2);
    add(0,    5, 28'h1234567, 2, 32'h7C000000, 4'b0000, 2);
    add(1,   91, 28'h1000000, 0, 32'hF8000000, 4'b0101, 2);
    add(0,  200, 28'h0000000, 0, 32'h43F00000, 4'b0000, 4);
    add(0, -300, 28'h1234567, 0, 32'h00000000, 4'b0011, 12);
    add(0, -102, 28'h0000025, 0, 32'h00000002, 4'b0011, 5);
    add(0, -102, 28'h0000035, 0, 32'h00000004, 4'b0011, 5);
    add(0, -102, 28'h9999999, 0, 32'h04000000, 4'b0011, 5);
    add(0, -101, 28'h0000001, 0, 32'h00000001, 4'b0000, 4);
    add(1,    0, 28'h0000001, 0, 32'hA2500001, 4'b0000, 4);

    foreach (vecs[i]) run(vecs[i], 0, $sformatf("vec%0d", i));

    // stall the output for ten cycles on the maximum finite value
    run(vecs[1], 10, "backpressure");

    // reset while ADJUST is still shifting a deep-subnormal input
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'(-300); in_coef = 28'h1234567; in_special = 2'b00;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("adj_reset_valid", 32'(out_valid), 32'd0);
    check("adj_reset_word", out_result, 32'd0);
    check("adj_reset_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("adj_reset_in_ready", 32'(in_ready), 32'd1);
    repeat (15) @(negedge clk);
    check("adj_reset_no_output", 32'(out_valid), 32'd0);

    // reset while a result waits in DONE
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_exp = 10'd91; in_coef = 28'h1000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_wait_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_reset_valid", 32'(out_valid), 32'd0);
    check("done_reset_word", out_result, 32'd0);
    check("done_reset_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_reset_in_ready", 32'(in_ready), 32'd1);

    run(vecs[0], 0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
